// File: rtl/spi_flash.sv
// Memory-mapped single-bit SPI master (mode 0, MSB first) for the serial configuration flash.
// Registers: DATA (0x0), STATUS (0x4), CS (0x8), DIV (0xC); only byte 0 of writes is used.
module spi_flash #(
  parameter logic [7:0] DEFAULT_DIV = 8'd3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        flash_clk,
  output logic        flash_csn,
  output logic        flash_io0_out,
  output logic        flash_io0_en,
  input  logic        flash_io1_in,
  output logic        flash_io1_out,
  output logic        flash_io1_en
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CS     = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  state_t      state_r;
  logic [7:0]  div_r;
  logic [7:0]  phase_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic [7:0]  rx_byte_r;
  logic        busy_r;

  logic [1:0]  reg_sel_s;
  logic        wr_s;
  logic [7:0]  shift_next_s;
  logic        unused_s;

  assign reg_sel_s    = address_in[3:2];
  assign wr_s         = sel_in && write_mask_in[0];
  assign shift_next_s = {shift_r[6:0], flash_io1_in};
  assign unused_s     = ^{address_in[31:4], address_in[1:0], write_mask_in[3:1], write_value_in[31:8]};

  assign flash_io1_out = 1'b0;
  assign flash_io1_en  = 1'b0;

  // Transfer FSM plus the software-visible CS and DIV registers; writes only land while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      div_r         <= DEFAULT_DIV;
      phase_r       <= 8'd0;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'd0;
      rx_byte_r     <= 8'd0;
      busy_r        <= 1'b0;
      flash_clk     <= 1'b0;
      flash_csn     <= 1'b1;
      flash_io0_out <= 1'b0;
      flash_io0_en  <= 1'b0;
    end else begin
      flash_io0_en <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (wr_s) begin
            case (reg_sel_s)
              REG_DATA: begin
                shift_r       <= write_value_in[7:0];
                flash_io0_out <= write_value_in[7];
                bit_cnt_r     <= 3'd7;
                phase_r       <= 8'd0;
                busy_r        <= 1'b1;
                state_r       <= ST_LOW;
              end
              REG_CS:     flash_csn <= write_value_in[0];
              REG_DIV:    div_r     <= write_value_in[7:0];
              REG_STATUS: busy_r    <= 1'b0;
              default:    busy_r    <= 1'b0;
            endcase
          end
        end
        ST_LOW: begin
          if (phase_r == div_r) begin
            flash_clk <= 1'b1;
            phase_r   <= 8'd0;
            state_r   <= ST_HIGH;
          end else begin
            phase_r <= phase_r + 8'd1;
          end
        end
        ST_HIGH: begin
          // MISO is captured on the edge that drops SCK; pad delay keeps it valid here.
          if (phase_r == div_r) begin
            shift_r   <= shift_next_s;
            flash_clk <= 1'b0;
            phase_r   <= 8'd0;
            if (bit_cnt_r == 3'd0) begin
              rx_byte_r <= shift_next_s;
              busy_r    <= 1'b0;
              state_r   <= ST_IDLE;
            end else begin
              bit_cnt_r     <= bit_cnt_r - 3'd1;
              flash_io0_out <= shift_r[6];
              state_r       <= ST_LOW;
            end
          end else begin
            phase_r <= phase_r + 8'd1;
          end
        end
        default: begin
          flash_clk <= 1'b0;
          busy_r    <= 1'b0;
          phase_r   <= 8'd0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered read port; returns zero outside a read of this block so it can be OR-ed onto the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_value_out <= 32'd0;
    end else if (sel_in && read_in) begin
      case (reg_sel_s)
        REG_DATA:   read_value_out <= {24'd0, rx_byte_r};
        REG_STATUS: read_value_out <= {30'd0, flash_csn, busy_r};
        REG_CS:     read_value_out <= {31'd0, flash_csn};
        REG_DIV:    read_value_out <= {24'd0, div_r};
        default:    read_value_out <= 32'd0;
      endcase
    end else begin
      read_value_out <= 32'd0;
    end
  end

endmodule

// File: tb/tb_spi_flash.sv
// Directed-plus-random bench for spi_flash; a flash model on the pins supplies MISO and
// records MOSI at every SCK rise, and each transfer is judged from first principles.
module tb_spi_flash;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        flash_clk;
  logic        flash_csn;
  logic        flash_io0_out;
  logic        flash_io0_en;
  logic        flash_io1_in = 1'b0;
  logic        flash_io1_out;
  logic        flash_io1_en;

  int          checks = 0;
  int          failures = 0;
  int          rise_total = 0;
  int          rise_base = 0;
  logic [7:0]  miso_byte = 8'h00;
  logic [7:0]  mosi_hist = 8'h00;
  logic [31:0] v;

  spi_flash #(.DEFAULT_DIV(8'd3)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address_in     (address_in),
    .sel_in         (sel_in),
    .read_in        (read_in),
    .read_value_out (read_value_out),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .flash_clk      (flash_clk),
    .flash_csn      (flash_csn),
    .flash_io0_out  (flash_io0_out),
    .flash_io0_en   (flash_io0_en),
    .flash_io1_in   (flash_io1_in),
    .flash_io1_out  (flash_io1_out),
    .flash_io1_en   (flash_io1_en)
  );

  always #5 clk = ~clk;

  // Flash model: on each SCK rise record MOSI and present the next MISO bit, MSB first.
  always @(posedge flash_clk) begin
    int k;
    logic [2:0] idx;
    k = rise_total - rise_base;
    idx = 3'(7 - k);
    flash_io1_in <= (k >= 0 && k < 8) ? miso_byte[idx] : 1'b0;
    mosi_hist    <= {mosi_hist[6:0], flash_io0_out};
    rise_total   <= rise_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end at a falling clock edge.
  task automatic bus_write(input logic [1:0] r, input logic [31:0] val, input logic [3:0] mask);
    address_in     = {28'd0, r, 2'b00};
    sel_in         = 1'b1;
    read_in        = 1'b0;
    write_mask_in  = mask;
    write_value_in = val;
    @(negedge clk);
    sel_in         = 1'b0;
    write_mask_in  = 4'h0;
    write_value_in = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] r, input logic sel, output logic [31:0] val);
    address_in = {28'd0, r, 2'b00};
    sel_in     = sel;
    read_in    = 1'b1;
    @(negedge clk);
    val     = read_value_out;
    sel_in  = 1'b0;
    read_in = 1'b0;
  endtask

  // One byte transfer; optionally pokes DATA/CS/DIV while busy, which must all be ignored.
  task automatic xfer(input logic [7:0] data, input logic [7:0] miso, input int div, input bit poke);
    int consumed;
    int polls;
    bit done;
    logic [31:0] st;
    miso_byte = miso;
    rise_base = rise_total;
    consumed  = 0;
    polls     = 0;
    done      = 1'b0;
    bus_write(2'd0, {24'd0, data}, 4'h1);
    if (poke) begin
      bus_write(2'd0, 32'h0000_0000, 4'hF);
      bus_write(2'd2, 32'h0000_0001, 4'hF);
      bus_write(2'd3, 32'h0000_0009, 4'hF);
      consumed = 3;
    end
    st = 32'd0;
    for (int i = 0; i < 5000 && !done; i++) begin
      bus_read(2'd1, 1'b1, st);
      if (st[0]) polls++;
      else done = 1'b1;
    end
    chk("xfer_done", {31'd0, done}, 32'd1);
    chk("busy_cycles", 32'(consumed + polls), 32'(16 * (div + 1)));
    chk("status_idle", st, 32'd0);
    chk("sck_pulses", 32'(rise_total - rise_base), 32'd8);
    chk("mosi_bits", {24'd0, mosi_hist}, {24'd0, data});
    chk("sck_idle_low", {31'd0, flash_clk}, 32'd0);
    bus_read(2'd0, 1'b1, st);
    chk("rx_byte", st, {24'd0, miso});
  endtask

  initial begin
    int div;
    logic [7:0] d;
    logic [7:0] m;
    reset_n        = 1'b0;
    address_in     = 32'd0;
    sel_in         = 1'b0;
    read_in        = 1'b0;
    write_mask_in  = 4'h0;
    write_value_in = 32'd0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_csn", {31'd0, flash_csn}, 32'd1);
    chk("rst_sck", {31'd0, flash_clk}, 32'd0);
    chk("rst_io0_en", {31'd0, flash_io0_en}, 32'd0);
    chk("rst_io0_out", {31'd0, flash_io0_out}, 32'd0);
    chk("rst_rdata", read_value_out, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_io0_en_before_edge", {31'd0, flash_io0_en}, 32'd0);
    @(negedge clk);
    chk("rel_io0_en_after_edge", {31'd0, flash_io0_en}, 32'd1);
    chk("io1_out", {31'd0, flash_io1_out}, 32'd0);
    chk("io1_en", {31'd0, flash_io1_en}, 32'd0);
    bus_read(2'd1, 1'b1, v); chk("rst_status", v, 32'h2);
    bus_read(2'd3, 1'b1, v); chk("rst_div", v, 32'h3);
    bus_read(2'd0, 1'b1, v); chk("rst_data", v, 32'h0);
    bus_read(2'd2, 1'b1, v); chk("rst_cs", v, 32'h1);

    // DIV=0, CS asserted, 0xA5 out / 0x3C in.
    bus_write(2'd3, 32'd0, 4'h1);
    bus_write(2'd2, 32'd0, 4'h1);
    bus_read(2'd2, 1'b1, v); chk("cs_asserted", v, 32'h0);
    chk("csn_pin", {31'd0, flash_csn}, 32'd0);
    xfer(8'hA5, 8'h3C, 0, 1'b0);

    // DIV=3, 0xFF.
    bus_write(2'd3, 32'd3, 4'h1);
    xfer(8'hFF, 8'($urandom), 3, 1'b0);

    // Writes while busy are dropped.
    xfer(8'hC3, 8'($urandom), 3, 1'b1);
    bus_read(2'd2, 1'b1, v); chk("cs_after_busy_write", v, 32'h0);
    bus_read(2'd3, 1'b1, v); chk("div_after_busy_write", v, 32'h3);

    // Byte-0 mask is required.
    bus_write(2'd3, 32'h0000_0007, 4'hE);
    bus_read(2'd3, 1'b1, v); chk("div_masked_write", v, 32'h3);

    // Read data only appears for a selected read, and only for one cycle.
    bus_read(2'd3, 1'b0, v); chk("read_unselected", v, 32'h0);
    bus_read(2'd3, 1'b1, v); chk("read_selected", v, 32'h3);
    @(negedge clk);
    chk("read_one_cycle", read_value_out, 32'h0);

    // Randomized transfers over a range of dividers.
    for (int n = 0; n < 6; n++) begin
      div = int'($urandom_range(0, 3));
      d   = 8'($urandom);
      m   = 8'($urandom);
      bus_write(2'd3, 32'(div), 4'h1);
      xfer(d, m, div, 1'b0);
    end

    // Reset in the middle of a transfer after 5 SCK pulses.
    bus_write(2'd3, 32'd1, 4'h1);
    miso_byte = 8'hFF;
    rise_base = rise_total;
    bus_write(2'd0, 32'h81, 4'h1);
    for (int i = 0; i < 1000 && (rise_total - rise_base) < 5; i++) @(negedge clk);
    chk("abort_reached_5_pulses", 32'(rise_total - rise_base), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_sck", {31'd0, flash_clk}, 32'd0);
    chk("abort_csn", {31'd0, flash_csn}, 32'd1);
    chk("abort_io0_out", {31'd0, flash_io0_out}, 32'd0);
    chk("abort_io0_en", {31'd0, flash_io0_en}, 32'd0);
    chk("abort_rdata", read_value_out, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(2'd0, 1'b1, v); chk("abort_data", v, 32'h0);
    bus_read(2'd1, 1'b1, v); chk("abort_status", v, 32'h2);
    bus_read(2'd3, 1'b1, v); chk("abort_div", v, 32'h3);
    bus_write(2'd2, 32'd0, 4'h1);
    xfer(8'($urandom), 8'($urandom), 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_flash.md
# spi_flash

Memory-mapped single-bit SPI master for the board's serial configuration flash. It sits on the CPU memory bus next to `ram`, `uart` and the LED register. It is selected by the top-level address decoder and drives the `flash_clk`/`flash_csn` pins and the `flash_io0`/`flash_io1` SB_IO cells. Software reads the flash by asserting chip-select, pushing command, address and dummy bytes through the data register, and polling busy.

## Interface
- `DEFAULT_DIV`, 8'd3: reset value of the divider register (SCK half-period = DIV+1 clk cycles).
- `clk` input 1: system clock (PLL clock).
- `reset_n` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `address_in` input 32: bus address; only bits [3:2] are decoded.
- `sel_in` input 1: block select from the top-level decoder.
- `read_in` input 1: bus read strobe.
- `read_value_out` output 32: registered read data; zero when not reading this block, so it can be OR-combined onto the bus.
- `write_mask_in` input 4: byte write enables.
- `write_value_in` input 32: bus write data.
- `flash_clk` output 1: SPI SCK, mode 0, idle low.
- `flash_csn` output 1: chip-select, active low.
- `flash_io0_out` output 1: MOSI data. `flash_io0_en` output 1: MOSI output enable.
- `flash_io1_in` input 1: MISO. `flash_io1_out` output 1: constant 0. `flash_io1_en` output 1: constant 0.

## Operation
Register map (offsets via `address_in[3:2]`; writes require `sel_in` and `write_mask_in[0]`; only byte 0 is used):
- 0x0 DATA:
  - Write while idle latches `[7:0]` into the shift register and starts an 8-bit MSB-first transfer.
  - Read returns `{24'b0, rx_byte}`, the last completed received byte.
- 0x4 STATUS (read only): bit0 busy, bit1 current `flash_csn`; other bits 0.
- 0x8 CS: write bit0 to `flash_csn` (1 = deasserted). Read returns bit0 = `flash_csn`.
- 0xC DIV: write `[7:0]` to the divider. Read returns `{24'b0, div}`.

Rules:
- Writes to DATA, CS or DIV while busy are ignored entirely. Software must wait for idle.
- Writes with `write_mask_in[0]`=0 are ignored.
- Reads have no side effects.

FSM states:
- IDLE: `flash_clk`=0, busy=0. A valid DATA write goes to LOW with bit counter=7, `flash_io0_out`=data[7], and the phase counter cleared.
- LOW: `flash_clk`=0. When the phase counter reaches DIV: set `flash_clk`=1, go to HIGH, clear the phase counter.
- HIGH: `flash_clk`=1. When the phase counter reaches DIV:
  - sample `flash_io1_in` into the shift register LSB and shift left;
  - set `flash_clk`=0;
  - if the bit counter is 0, copy the shifted byte to `rx_byte` and go to IDLE;
  - otherwise decrement the bit counter, present the next MSB on `flash_io0_out`, and go to LOW.

Other behaviour:
- MISO is sampled on the clk edge that drives SCK low. Pad delay keeps flash data valid at that edge.
- The phase counter is 8 bits and compares for equality with `div`. DIV=255 gives a 256-cycle half-period, and the counter never wraps past DIV.
- `flash_io0_en`=1 whenever out of reset.

## Timing
Reset values (asynchronous, while `reset_n`=0):
- `flash_clk`=0, `flash_csn`=1, `flash_io0_out`=0, `flash_io0_en`=0, `read_value_out`=0.
- busy=0, `rx_byte`=0, div=`DEFAULT_DIV`, FSM in IDLE.

Cycle-level behaviour:
- First rising clk edge after reset release: `flash_io0_en` goes to 1.
- DATA write accepted at edge T:
  - busy=1 and MOSI=bit7 from T+1.
  - First SCK rise at T+1+(DIV+1).
  - busy lasts exactly 16×(DIV+1) cycles.
  - The final SCK fall, the `rx_byte` update and busy=0 all take effect on the same edge.
- A STATUS read issued on the cycle busy falls returns busy=0 and new DATA.
- Reads: `read_value_out` is valid one cycle after `sel_in && read_in`, and is 0 in all other cycles.
- A DATA write and a STATUS read cannot coincide, because the bus carries a single access per cycle.
- `reset_n` asserted mid-transfer aborts immediately. All outputs take their reset values; no partial byte reaches `rx_byte`.

## Test plan
- Reset: hold `reset_n`=0 → `flash_csn`=1, `flash_clk`=0, `flash_io0_en`=0, STATUS=0x2, DIV reads 3. Release → `flash_io0_en`=1 one cycle later.
- DIV=0, CS=0, write DATA=0xA5, MISO model returns 0x3C:
  - MOSI bits observed at SCK rises are 1,0,1,0,0,1,0,1.
  - busy=1 for exactly 16 cycles, then DATA reads 0x3C.
- DIV=3, write DATA=0xFF → SCK period 8 cycles, 8 pulses, busy=1 for 64 cycles, `flash_clk`=0 after completion.
- During busy, write DATA=0x00, CS=1 and DIV=9 → all ignored: transfer completes unchanged, CS still 0, DIV still 3.
- Read DATA with `sel_in`=0 → `read_value_out`=0. Read with `sel_in`=1 → value appears the next cycle only.
- Assert `reset_n`=0 after 5 SCK pulses → outputs reset immediately. DATA reads 0x00 after release, and a new transfer works normally.
